// File: rtl/skid_fifo.sv
// DEPTH-entry elastic valid/ready buffer with registered in_ready/out_valid,
// occupancy reporting, an almost-full flag and a synchronous flush.
module skid_fifo #(
  parameter int DATA_WIDTH        = 32,
  parameter int DEPTH             = 4,
  parameter int ALMOST_FULL_LEVEL = 3
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  almost_full_q, almost_full_d;
  logic                  push, pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // Flush discards any handshake of the same cycle along with the contents.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
    in_ready_d    = (level_d != LVL_W'(DEPTH));
    out_valid_d   = (level_d != '0);
    almost_full_d = (level_d >= LVL_W'(ALMOST_FULL_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Storage is not reset; a write during flush or reset lands behind cleared pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_data    = mem_q[rd_ptr_q];
  assign out_valid   = out_valid_q;
  assign in_ready    = in_ready_q;
  assign level       = level_q;
  assign almost_full = almost_full_q;

endmodule

// File: tb/tb_skid_fifo.sv
// Directed bench for skid_fifo (DEPTH=4): reset, streaming, fill/drain,
// randomized stalls against a queue model, and flush.
module tb_skid_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    level;
  logic          almost_full;

  int n_cmp = 0;
  int n_err = 0;

  skid_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_LEVEL(3)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] q[$];
    int mlevel, pushed, popped, cyc;
    bit mpush, mpop;
    logic [2:0]  lv_exp [6];
    logic        af_exp [6];
    logic        ir_exp [6];
    logic [31:0] od_exp [6];

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b0;

    // 1. reset held for three edges
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_level", level, 0);
    end
    resetn = 1'b1; in_valid = 1'b0;
    step();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    chk("rel_level", level, 0);

    // 2. streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = i;
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, i);
      chk("stream_level", level, 1);
      chk("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_empty", out_valid, 0);
    chk("stream_level0", level, 0);

    // 3. fill under backpressure
    out_ready = 1'b0; in_valid = 1'b1;
    lv_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    af_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ir_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      in_data = (i < 4) ? 32'hA0 + i : 32'hA4;
      step();
      chk("fill_level", level, lv_exp[i]);
      chk("fill_af", almost_full, af_exp[i]);
      chk("fill_in_ready", in_ready, ir_exp[i]);
      chk("fill_head", out_data, 32'hA0);
      chk("fill_valid", out_valid, 1);
    end

    // 4. drain from full with upstream still offering A4, A5
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA4;
    lv_exp = '{3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    od_exp = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'h0};
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 1) in_data = 32'hA5;
      if (i == 2) in_valid = 1'b0;
      chk("drain_level", level, lv_exp[i]);
      chk("drain_in_ready", in_ready, 1);
      chk("drain_valid", out_valid, (i < 5) ? 1 : 0);
      if (i < 5) chk("drain_data", out_data, od_exp[i]);
    end

    // 5. random stalls against a queue model
    mlevel = 0; pushed = 0; popped = 0; cyc = 0;
    while (popped < 13 && cyc < 500) begin
      in_valid  = (pushed < 13) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      mpush = in_valid && (mlevel != DEPTH);
      mpop  = out_ready && (mlevel != 0);
      chk("rnd_in_ready", in_ready, (mlevel != DEPTH) ? 1 : 0);
      chk("rnd_out_valid", out_valid, (mlevel != 0) ? 1 : 0);
      if (mpop) begin
        chk("rnd_data", out_data, q[0]);
        void'(q.pop_front());
        popped++;
      end
      if (mpush) begin
        q.push_back(in_data);
        pushed++;
      end
      mlevel = mlevel + int'(mpush) - int'(mpop);
      step();
      cyc++;
      chk("rnd_level", level, mlevel);
    end
    chk("rnd_done", popped, 13);
    in_valid = 1'b0; out_ready = 1'b0;

    // 6. flush at level 3 with a simultaneous push
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h31 + i;
      step();
    end
    chk("pre_flush_level", level, 3);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h77;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_af", almost_full, 0);
    in_valid = 1'b1; in_data = 32'h55;
    step();
    in_valid = 1'b0;
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_data", out_data, 32'h55);
    chk("post_flush_level", level, 1);
    out_ready = 1'b1;
    step();
    chk("post_flush_empty", out_valid, 0);
    chk("post_flush_level0", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/skid_fifo.md
Name: skid_fifo

Overview:
Parametrised successor to the single-entry skid buffer: a DEPTH-entry elastic valid/ready buffer with full-rate throughput and registered handshake outputs.
- in_ready and out_valid are flops, so no combinational path exists from out_ready to in_ready or from in_* to out_*.
- Adds occupancy reporting, an almost-full flag and a synchronous flush.
- Sits between AXI/AXI-Lite/AXI-Stream channel stages in the example cores, for timing closure and burst absorption.

Parameters:
DATA_WIDTH, 32, payload width in bits.
DEPTH, 4, number of storage entries; power of 2, >= 2.
ALMOST_FULL_LEVEL, 3, occupancy at or above which almost_full asserts; 1..DEPTH.

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
flush  input  1  synchronous discard of all contents
in_data  input  DATA_WIDTH  upstream payload
in_valid  input  1  upstream valid
in_ready  output  1  registered; buffer can accept this cycle
out_data  output  DATA_WIDTH  payload at head of buffer
out_valid  output  1  registered; head entry valid
out_ready  input  1  downstream ready
level  output  $clog2(DEPTH+1)  registered occupancy, 0..DEPTH
almost_full  output  1  registered; level >= ALMOST_FULL_LEVEL

Behaviour:
- Reset:
  - At any edge with resetn=0: in_ready=0, out_valid=0, level=0, almost_full=0; write/read pointers cleared.
  - out_data is don't-care while out_valid=0.
  - First edge with resetn=1 sets in_ready=1.
- Transfers:
  - push = in_valid && in_ready; pop = out_valid && out_ready.
  - in_data is ignored when in_ready=0.
- Storage and pointers:
  - Register array mem[DEPTH]; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - Count is kept separately (level register), not derived from pointers.
- Next-state rules:
  - level_next = level + push - pop.
  - in_ready <= (level_next != DEPTH).
  - out_valid <= (level_next != 0).
  - almost_full <= (level_next >= ALMOST_FULL_LEVEL).
- Data:
  - On push, mem[wr_ptr] <= in_data and wr_ptr increments.
  - On pop, rd_ptr increments.
  - out_data = mem[rd_ptr], a read mux from registers only.
- Latency:
  - A word pushed into an empty buffer at edge N is presented with out_valid=1 after edge N (one cycle).
  - No same-cycle fall-through.
- Throughput:
  - One word per cycle sustained while out_ready=1.
  - in_ready never drops while level_next < DEPTH.
- Simultaneous push and pop:
  - level unchanged; both pointers advance.
  - This is legal at any level 1..DEPTH-1.
  - At level=DEPTH no push is possible because in_ready=0.
- Full:
  - in_ready deasserts the cycle after the push that reaches DEPTH.
  - A pop at full re-asserts in_ready the following cycle.
  - No entry is overwritten, ever.
- Empty:
  - out_valid=0.
  - A pop cannot occur; out_ready is ignored.
- Stability:
  - While out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- Flush (resetn=1, flush=1 at edge):
  - Pointers cleared; level=0, out_valid=0, almost_full=0, in_ready=1.
  - Any push or pop handshake in that same cycle is discarded; upstream must not rely on it.
- Reset priority:
  - resetn=0 overrides flush.
  - Reset mid-burst discards all contents with no partial output.

Test Plan:
1. Reset: DEPTH=4; hold resetn=0 for 3 cycles with in_valid=1, in_data=0x11 -> in_ready=0, out_valid=0, level=0 throughout. After release, in_ready=1 one cycle later; nothing emitted.
2. Streaming: out_ready=1; push 0x00..0x09 back-to-back -> each word appears on out_data exactly 1 cycle after acceptance, in order. in_ready stays 1; level never exceeds 1.
3. Fill under backpressure: out_ready=0; offer 0xA0..0xA5 continuously -> exactly A0..A3 accepted. in_ready=0 from the cycle after A3; level=4. almost_full=1 from the cycle after A2 (level 3). out_data holds 0xA0 stable.
4. Drain from full with in_valid held: raise out_ready=1 -> in_ready re-asserts one cycle after first pop. Output sequence is A0,A1,A2,A3,A4,A5 with no loss or duplication.
5. Wrap and random stalls: 3*DEPTH+1 = 13 random words with random in_valid/out_ready (50%) -> scoreboard matches in order. level always equals pushes minus pops.
6. Flush: at level=3, assert flush with a simultaneous push of 0x77 -> next cycle level=0, out_valid=0, in_ready=1; 0x77 is never output. A subsequent push of 0x55 appears on out_data one cycle later.
